// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync_fifo read port into a
// framed valid/ready stream through a 3-entry skid queue.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RDATA_MODE = 1,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  busy,
  output logic                  err_underflow
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            occ;
  logic                  infl;
  logic [15:0]           beat;
  logic [2:0]            level;
  logic                  push;
  logic                  pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are throttled by buffered plus in-flight words only,
  // so m_ready never reaches the FIFO strobe combinationally.
  assign level      = {1'b0, occ} + {2'b0, infl};
  assign fifo_rd_en = rst_n & en & ~fifo_empty & (level < 3'd3);

  assign push    = (RDATA_MODE == 0) ? fifo_rd_en : infl;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid & (beat == LAST_BEAT);
  assign busy    = m_valid | infl;

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fifo_rd_data;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Tracks a read whose data arrives on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) infl <= 1'b0;
    else        infl <= (RDATA_MODE == 1) ? fifo_rd_en : 1'b0;
  end

  // Beat position within the packet and completed packet count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= 16'd0;
      pkt_cnt <= '0;
    end else if (pop) begin
      if (m_last) begin
        beat    <= 16'd0;
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end else begin
        beat    <= beat + 16'd1;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_underflow <= 1'b0;
    else        err_underflow <= err_underflow | fifo_underflow;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: runs a show-ahead and a registered-read
// reader side by side against a queue-based FIFO/stream model.
module tb_fifo_stream_reader;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       m_ready;
  logic       force_uf;
  logic       rd_en   [2];
  logic       empty   [2];
  logic       uf      [2];
  logic       m_valid [2];
  logic       m_last  [2];
  logic       busy    [2];
  logic       err     [2];
  logic [7:0] rd_data [2];
  logic [7:0] m_data  [2];
  logic [15:0] pkt    [2];

  logic [7:0] fq  [2][$];
  logic [7:0] exq [2][$];
  int reads [2];
  int hs    [2];
  bit inf   [2];
  bit fire  [2];
  bit ufs   [2];
  bit lastb [2];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign uf[0] = force_uf | (rd_en[0] & empty[0]);
  assign uf[1] = force_uf | (rd_en[1] & empty[1]);

  fifo_stream_reader #(
    .DATA_WIDTH(8), .RDATA_MODE(0), .PKT_LEN(P), .CNT_WIDTH(16)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]),
    .fifo_empty(empty[0]), .fifo_underflow(uf[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready),
    .m_data(m_data[0]), .m_last(m_last[0]),
    .pkt_cnt(pkt[0]), .busy(busy[0]),
    .err_underflow(err[0])
  );

  fifo_stream_reader #(
    .DATA_WIDTH(8), .RDATA_MODE(1), .PKT_LEN(P), .CNT_WIDTH(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]),
    .fifo_empty(empty[1]), .fifo_underflow(uf[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready),
    .m_data(m_data[1]), .m_last(m_last[1]),
    .pkt_cnt(pkt[1]), .busy(busy[1]),
    .err_underflow(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic string tg(input string s, input int k);
    return $sformatf("%s%0d", s, k);
  endfunction

  task automatic refresh();
    for (int k = 0; k < 2; k++) empty[k] = (fq[k].size() == 0);
    rd_data[0] = empty[0] ? 8'h00 : fq[0][0];
  endtask

  task automatic push(input logic [7:0] w);
    for (int k = 0; k < 2; k++) begin
      fq[k].push_back(w);
      exq[k].push_back(w);
    end
    refresh();
  endtask

  // Predicts every output from word counts: words read but not yet
  // delivered sit in the reader; a mode-1 read lands one edge later.
  task automatic mon();
    int lvl;
    int cap;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      fire[k] = 1'b0;
      if (rst_n) begin
        lvl = reads[k] - hs[k];
        cap = lvl - ((k == 1 && inf[k]) ? 1 : 0);
        chk(tg("rd_en", k), 32'(rd_en[k]),
            32'(en & ~empty[k] & (lvl < 3)));
        chk(tg("m_valid", k), 32'(m_valid[k]), 32'(cap != 0));
        chk(tg("busy", k), 32'(busy[k]), 32'(lvl != 0));
        chk(tg("pkt_cnt", k), 32'(pkt[k]), 32'((hs[k] / P) % 65536));
        chk(tg("err_uf", k), 32'(err[k]), 32'(ufs[k]));
        chk(tg("m_last", k), 32'(m_last[k]),
            32'((cap != 0) && (hs[k] % P == P - 1)));
        if (m_valid[k] && m_ready) begin
          chk(tg("have_word", k), 32'(exq[k].size() != 0), 1);
          w = (exq[k].size() != 0) ? exq[k].pop_front() : 8'h00;
          chk(tg("m_data", k), 32'(m_data[k]), 32'(w));
          lastb[k] = m_last[k];
          hs[k]++;
        end
        fire[k] = rd_en[k];
        if (rd_en[k]) reads[k]++;
        inf[k] = rd_en[k];
        if (uf[k]) ufs[k] = 1'b1;
      end
    end
  endtask

  task automatic fifo_update();
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      if (fire[k]) begin
        w = (fq[k].size() != 0) ? fq[k].pop_front() : 8'h00;
        if (k == 1) rd_data[1] = w;
      end
    end
    refresh();
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    fifo_update();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    force_uf = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fq[k].delete();
      exq[k].delete();
      reads[k] = 0;
      hs[k]    = 0;
      inf[k]   = 1'b0;
      fire[k]  = 1'b0;
      ufs[k]   = 1'b0;
    end
    rd_data[1] = 8'h00;
    refresh();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(tg("rst_rd_en", k), 32'(rd_en[k]), 0);
      chk(tg("rst_valid", k), 32'(m_valid[k]), 0);
      chk(tg("rst_data", k), 32'(m_data[k]), 0);
      chk(tg("rst_last", k), 32'(m_last[k]), 0);
      chk(tg("rst_pkt", k), 32'(pkt[k]), 0);
      chk(tg("rst_busy", k), 32'(busy[k]), 0);
      chk(tg("rst_err", k), 32'(err[k]), 0);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      done = (exq[0].size() == 0) && (exq[1].size() == 0) &&
             !busy[0] && !busy[1];
      if (!done) cyc();
    end
    chk("drain_done", 32'(done), 1);
  endtask

  initial begin
    int lat [2];
    int cnt [2];
    int p0;
    int n;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; force_uf = 1'b0;
    rd_data[0] = 8'h00; rd_data[1] = 8'h00;
    refresh();
    #1;
    do_reset();

    // Single packet with first-word latency.
    push(8'ha5); push(8'ha6); push(8'ha7); push(8'ha8);
    en = 1'b1; m_ready = 1'b1;
    lat[0] = 0; lat[1] = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      for (int k = 0; k < 2; k++)
        if (lat[k] == 0 && m_valid[k]) lat[k] = i;
    end
    chk("latency0", 32'(lat[0]), 1);
    chk("latency1", 32'(lat[1]), 2);
    drain();
    chk("pkt_a0", 32'(pkt[0]), 1);
    chk("pkt_a1", 32'(pkt[1]), 1);

    // Backpressure with six words queued.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'hb0 + 8'(i));
    cnt[0] = 0; cnt[1] = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) cnt[k] += int'(fire[k]);
    end
    chk("bp_reads0", 32'(cnt[0]), 3);
    chk("bp_reads1", 32'(cnt[1]), 3);
    chk("bp_head0", 32'(m_data[0]), 32'hb0);
    chk("bp_head1", 32'(m_data[1]), 32'hb0);
    m_ready = 1'b1;
    drain();

    // Eight-word burst spans exactly two packet ends.
    p0 = int'(pkt[0]);
    for (int i = 0; i < 8; i++) push(8'($urandom));
    drain();
    chk("burst_pkt0", 32'(pkt[0]), 32'(p0 + 2));
    chk("burst_pkt1", 32'(pkt[1]), 32'(p0 + 2));

    // Enable dropped after two reads.
    en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hc0 + 8'(i));
    en = 1'b1;
    cnt[0] = 0; cnt[1] = 0;
    cyc(); cnt[0] += int'(fire[0]); cnt[1] += int'(fire[1]);
    cyc(); cnt[0] += int'(fire[0]); cnt[1] += int'(fire[1]);
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      for (int k = 0; k < 2; k++) cnt[k] += int'(fire[k]);
    end
    chk("endrop_reads0", 32'(cnt[0]), 2);
    chk("endrop_reads1", 32'(cnt[1]), 2);
    chk("endrop_busy1", 32'(busy[1]), 0);
    chk("endrop_valid1", 32'(m_valid[1]), 0);
    en = 1'b1;
    drain();

    // FIFO runs dry mid-packet; a later word closes the packet.
    n = (P - (hs[0] % P)) % P;
    for (int i = 0; i < n; i++) push(8'($urandom));
    drain();
    p0 = int'(pkt[0]);
    push(8'hd0); push(8'hd1); push(8'hd2);
    drain();
    for (int i = 0; i < 3; i++) cyc();
    chk("dry_valid0", 32'(m_valid[0]), 0);
    chk("dry_pkt0", 32'(pkt[0]), 32'(p0));
    push(8'hd3);
    drain();
    chk("dry_last0", 32'(lastb[0]), 1);
    chk("dry_last1", 32'(lastb[1]), 1);
    chk("dry_pkt1", 32'(pkt[1]), 32'(p0 + 1));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) push(8'($urandom));
      en      = ($urandom_range(7) != 0);
      m_ready = ($urandom_range(3) != 0);
      cyc();
    end
    en = 1'b1; m_ready = 1'b1;
    drain();

    // Reset mid-stream, then sticky underflow.
    m_ready = 1'b0;
    push(8'he0); push(8'he1);
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_rst_busy1", 32'(busy[1]), 1);
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < P; i++) push(8'hf0 + 8'(i));
    drain();
    chk("post_rst_pkt0", 32'(pkt[0]), 1);
    chk("post_rst_pkt1", 32'(pkt[1]), 1);
    force_uf = 1'b1;
    cyc();
    force_uf = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    chk("uf_sticky0", 32'(err[0]), 1);
    chk("uf_sticky1", 32'(err[1]), 1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
